tx_frame_packer: RTL and testbench

//  Transmit-side framer for the host<->FPGA UART link. Accepts 24-bit RGB pixels

---
 rtl/uart_frame_pkg.sv | 33 +++
 rtl/tx_frame_packer.sv | 139 +++++++++++++
 tb/tb_tx_frame_packer.sv | 386 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_frame_pkg.sv
// Shared framing constants and TX state encoding for the host<->FPGA UART link.
// TX_FRAME_CHECKSUM_EN adds the trailing checksum state.
package uart_frame_pkg;

   localparam logic [7:0] START_BYTE_DEF = 8'h02;
   localparam logic [7:0] STOP_BYTE_DEF  = 8'h03;
   localparam int         PIX_CNT_W_DEF  = 19;

   // Byte lanes of a packed {R,G,B} pixel; the RX assembler uses the same map.
   localparam int R_LSB = 16;
   localparam int G_LSB = 8;
   localparam int B_LSB = 0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SOF,
      ST_WAIT,
      ST_R,
      ST_G,
      ST_B,
`ifdef TX_FRAME_CHECKSUM_EN
      ST_EOF,
      ST_CSUM
`else
      ST_EOF
`endif
   } tx_state_t;

   function automatic logic [7:0] rgb_lane(input logic [23:0] px, input int lsb);
      return px[lsb +: 8];
   endfunction

endpackage

// File: rtl/tx_frame_packer.sv
// Serialises start/pixel/stop requests into START, {R,G,B}*, STOP bytes for the UART TX FIFO.
// TX_FRAME_CHECKSUM_EN appends an XOR checksum of all pixel bytes after STOP.
module tx_frame_packer
   import uart_frame_pkg::*;
#(
   parameter logic [7:0] START_BYTE = START_BYTE_DEF,
   parameter logic [7:0] STOP_BYTE  = STOP_BYTE_DEF,
   parameter int         PIX_CNT_W  = PIX_CNT_W_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 stop,
   input  logic                 rgb_valid,
   input  logic [23:0]          rgb_data,
   output logic                 rgb_ready,
   input  logic                 full,
   output logic                 push,
   output logic [7:0]           push_data,
   output logic                 busy,
   output logic                 frame_done,
   output logic [PIX_CNT_W-1:0] pix_count
);

   tx_state_t            state_q;
   logic [23:0]          pix_q;
   logic                 stop_q;
   logic                 busy_q;
   logic                 frame_done_q;
   logic [PIX_CNT_W-1:0] pix_count_q;
   logic [PIX_CNT_W-1:0] pix_count_d;
   logic                 byte_state;
`ifdef TX_FRAME_CHECKSUM_EN
   logic [7:0]           csum_q;
`endif

   always_comb begin
      byte_state = 1'b0;
      push_data  = 8'h00;
      case (state_q)
         ST_SOF:  begin byte_state = 1'b1; push_data = START_BYTE;             end
         ST_R:    begin byte_state = 1'b1; push_data = rgb_lane(pix_q, R_LSB); end
         ST_G:    begin byte_state = 1'b1; push_data = rgb_lane(pix_q, G_LSB); end
         ST_B:    begin byte_state = 1'b1; push_data = rgb_lane(pix_q, B_LSB); end
         ST_EOF:  begin byte_state = 1'b1; push_data = STOP_BYTE;              end
`ifdef TX_FRAME_CHECKSUM_EN
         ST_CSUM: begin byte_state = 1'b1; push_data = csum_q;                 end
`endif
         default: begin byte_state = 1'b0; push_data = 8'h00;                  end
      endcase
   end

   // Saturate rather than wrap so an oversized frame still reads as "at least max".
   assign pix_count_d = (&pix_count_q) ? pix_count_q : pix_count_q + 1'b1;

   assign push       = byte_state && !full;
   assign rgb_ready  = (state_q == ST_WAIT);
   assign busy       = busy_q;
   assign frame_done = frame_done_q;
   assign pix_count  = pix_count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         pix_q        <= '0;
         stop_q       <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         pix_count_q  <= '0;
`ifdef TX_FRAME_CHECKSUM_EN
         csum_q       <= 8'h00;
`endif
      end else begin
         frame_done_q <= 1'b0;
         // A stop seen while a byte is still pending is held until WAIT.
         if (stop && (state_q inside {ST_SOF, ST_R, ST_G, ST_B}))
            stop_q <= 1'b1;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_q     <= ST_SOF;
                  busy_q      <= 1'b1;
                  pix_count_q <= '0;
                  stop_q      <= 1'b0;
`ifdef TX_FRAME_CHECKSUM_EN
                  csum_q      <= 8'h00;
`endif
               end
            end
            ST_SOF: if (push) state_q <= ST_WAIT;
            ST_WAIT: begin
               if (rgb_valid) begin
                  pix_q   <= rgb_data;
                  state_q <= ST_R;
                  if (stop) stop_q <= 1'b1;
`ifdef TX_FRAME_CHECKSUM_EN
                  csum_q  <= csum_q ^ rgb_lane(rgb_data, R_LSB)
                                    ^ rgb_lane(rgb_data, G_LSB)
                                    ^ rgb_lane(rgb_data, B_LSB);
`endif
               end else if (stop || stop_q) begin
                  stop_q  <= 1'b0;
                  state_q <= ST_EOF;
               end
            end
            ST_R: if (push) state_q <= ST_G;
            ST_G: if (push) state_q <= ST_B;
            ST_B: begin
               if (push) begin
                  state_q     <= ST_WAIT;
                  pix_count_q <= pix_count_d;
               end
            end
            ST_EOF: begin
               if (push) begin
`ifdef TX_FRAME_CHECKSUM_EN
                  state_q      <= ST_CSUM;
`else
                  state_q      <= ST_IDLE;
                  busy_q       <= 1'b0;
                  frame_done_q <= 1'b1;
`endif
               end
            end
`ifdef TX_FRAME_CHECKSUM_EN
            ST_CSUM: begin
               if (push) begin
                  state_q      <= ST_IDLE;
                  busy_q       <= 1'b0;
                  frame_done_q <= 1'b1;
               end
            end
`endif
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tx_frame_packer.sv
// Self-checking bench for tx_frame_packer; expected byte streams come from a frame-level model.
// Define TX_FRAME_CHECKSUM_EN for both RTL and bench to exercise the checksum build.
`timescale 1ns/1ps
module tb_tx_frame_packer;

   localparam int PW = 19;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          stop = 1'b0;
   logic          rgb_valid = 1'b0;
   logic [23:0]   rgb_data = 24'h0;
   logic          full = 1'b0;
   logic          rgb_ready;
   logic          push;
   logic [7:0]    push_data;
   logic          busy;
   logic          frame_done;
   logic [PW-1:0] pix_count;

   int errors = 0;
   int checks = 0;
   int cycle = 0;
   int last_push_cyc = -10;
   int fd_cyc = -10;
   int fd_pulses = 0;
   int acc_cyc = -10;
   logic fd_busy = 1'b0;
   bit rand_full_en = 1'b0;

   logic [7:0]  got_q[$];
   int          gotc_q[$];
   logic [7:0]  exp_q[$];
   logic [23:0] px_q[$];

   tx_frame_packer dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
      .rgb_valid(rgb_valid), .rgb_data(rgb_data), .rgb_ready(rgb_ready),
      .full(full), .push(push), .push_data(push_data), .busy(busy),
      .frame_done(frame_done), .pix_count(pix_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycle++;

   always @(posedge clk) begin
      if (rand_full_en) begin
         #1 full = ($urandom_range(0, 2) == 0);
      end
   end

   // Capture every byte the FIFO would accept, and frame_done timing.
   always @(negedge clk) begin
      if (push === 1'b1) begin
         checks++;
         if (full !== 1'b0) begin
            errors++;
            $display("FAIL push_while_full: push=%b full=%b cycle=%0d", push, full, cycle);
         end
         got_q.push_back(push_data);
         gotc_q.push_back(cycle);
         last_push_cyc = cycle;
      end
      if (frame_done === 1'b1) begin
         fd_cyc = cycle;
         fd_pulses++;
         fd_busy = busy;
      end
   end

   // Reference: the byte list a frame must produce, straight from the framing rules.
   task automatic model_frame();
      logic [7:0] cs;
      logic [7:0] b;
      cs = 8'h00;
      exp_q.delete();
      exp_q.push_back(8'h02);
      foreach (px_q[i]) begin
         for (int lane = 2; lane >= 0; lane--) begin
            b = 8'((px_q[i] >> (8 * lane)) & 24'hFF);
            exp_q.push_back(b);
            cs = cs ^ b;
         end
      end
      exp_q.push_back(8'h03);
`ifdef TX_FRAME_CHECKSUM_EN
      exp_q.push_back(cs);
`endif
   endtask

   task automatic clear_capture();
      got_q.delete();
      gotc_q.delete();
      fd_pulses = 0;
      fd_cyc = -10;
      last_push_cyc = -10;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic pulse_stop();
      stop = 1'b1;
      @(posedge clk);
      #1 stop = 1'b0;
   endtask

   task automatic send_pixel(input logic [23:0] px, output bit ok);
      int n;
      n = 0;
      rgb_valid = 1'b1;
      rgb_data = px;
      @(negedge clk);
      while (rgb_ready !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      ok = (rgb_ready === 1'b1);
      acc_cyc = cycle;
      @(posedge clk);
      #1 rgb_valid = 1'b0;
   endtask

   task automatic wait_idle(output bit ok);
      int n;
      n = 0;
      @(negedge clk);
      while (busy !== 1'b0 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      ok = (busy === 1'b0);
      @(posedge clk);
      #1;
   endtask

   task automatic report_timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s_timeout: handshake or frame end not seen within cycle budget", name);
   endtask

   task automatic check_stream(input string name);
      checks++;
      if (got_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL %s_len: got %0d bytes, expected %0d", name, got_q.size(), exp_q.size());
      end else begin
         foreach (exp_q[i]) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
               errors++;
               $display("FAIL %s_byte%0d: got %h, expected %h", name, i, got_q[i], exp_q[i]);
            end
         end
         $display("%s: %0d bytes, pix_count=%0d", name, got_q.size(), pix_count);
      end
   endtask

   task automatic check_done(input string name, input int npix);
      checks++;
      if (pix_count !== PW'(npix)) begin
         errors++;
         $display("FAIL %s_pix_count: got %0d, expected %0d", name, pix_count, npix);
      end
      checks++;
      if (fd_pulses != 1) begin
         errors++;
         $display("FAIL %s_done_pulses: got %0d, expected 1", name, fd_pulses);
      end
      checks++;
      if (fd_cyc != last_push_cyc + 1) begin
         errors++;
         $display("FAIL %s_done_timing: frame_done cycle %0d, expected %0d", name, fd_cyc, last_push_cyc + 1);
      end
      checks++;
      if (fd_busy !== 1'b0) begin
         errors++;
         $display("FAIL %s_busy_at_done: got %b, expected 0", name, fd_busy);
      end
   endtask

   task automatic run_frame(input string name, input int gap_max);
      bit ok;
      int g;
      clear_capture();
      pulse_start();
      foreach (px_q[i]) begin
         send_pixel(px_q[i], ok);
         if (!ok) report_timeout(name);
         g = $urandom_range(0, gap_max);
         repeat (g) begin @(posedge clk); #1; end
      end
      pulse_stop();
      wait_idle(ok);
      if (!ok) report_timeout(name);
      model_frame();
      check_stream(name);
      check_done(name, px_q.size());
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({push, busy, rgb_ready, frame_done} !== 4'b0000 || push_data !== 8'h00 || pix_count !== '0) begin
         errors++;
         $display("FAIL reset_state: push=%b busy=%b ready=%b done=%b data=%h cnt=%0d, expected all zero",
                  push, busy, rgb_ready, frame_done, push_data, pix_count);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      $display("test_reset: outputs idle");
   endtask

   task automatic test_single_pixel();
      bit ok;
      int s;
      clear_capture();
      px_q = '{24'h112233};
      s = cycle;
      pulse_start();
      send_pixel(24'h112233, ok);
      if (!ok) report_timeout("single");
      pulse_stop();
      wait_idle(ok);
      if (!ok) report_timeout("single");
      model_frame();
      check_stream("single");
      check_done("single", 1);
      if (gotc_q.size() >= 4) begin
         checks++;
         if (gotc_q[0] != s + 1) begin
            errors++;
            $display("FAIL start_latency: SOF pushed at %0d, expected %0d", gotc_q[0], s + 1);
         end
         checks++;
         if (gotc_q[1] != acc_cyc + 1 || gotc_q[2] != acc_cyc + 2 || gotc_q[3] != acc_cyc + 3) begin
            errors++;
            $display("FAIL pixel_latency: RGB at %0d,%0d,%0d, expected %0d..%0d",
                     gotc_q[1], gotc_q[2], gotc_q[3], acc_cyc + 1, acc_cyc + 3);
         end
      end
   endtask

   task automatic test_full_stall();
      bit ok;
      clear_capture();
      px_q = '{24'h112233};
      pulse_start();
      send_pixel(24'h112233, ok);
      if (!ok) report_timeout("stall");
      @(posedge clk);
      #1 full = 1'b1;
      repeat (5) begin
         @(negedge clk);
         checks++;
         if (push !== 1'b0) begin
            errors++;
            $display("FAIL stall_push: got %b, expected 0 while full", push);
         end
      end
      @(posedge clk);
      #1 full = 1'b0;
      pulse_stop();
      wait_idle(ok);
      if (!ok) report_timeout("stall");
      model_frame();
      check_stream("stall");
      check_done("stall", 1);
   endtask

   task automatic test_valid_stop_same();
      bit ok;
      int n;
      clear_capture();
      px_q = '{24'hA1B2C3};
      pulse_start();
      n = 0;
      @(negedge clk);
      while (rgb_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      if (rgb_ready !== 1'b1) report_timeout("same_cycle");
      rgb_valid = 1'b1;
      rgb_data = 24'hA1B2C3;
      stop = 1'b1;
      @(posedge clk);
      #1;
      rgb_valid = 1'b0;
      stop = 1'b0;
      wait_idle(ok);
      if (!ok) report_timeout("same_cycle");
      model_frame();
      check_stream("same_cycle");
      check_done("same_cycle", 1);
   endtask

   task automatic test_ignored_controls();
      bit ok;
      clear_capture();
      px_q = '{24'h445566, 24'h778899};
      pulse_start();
      send_pixel(px_q[0], ok);
      if (!ok) report_timeout("ignored");
      pulse_start();
      send_pixel(px_q[1], ok);
      if (!ok) report_timeout("ignored");
      pulse_stop();
      wait_idle(ok);
      if (!ok) report_timeout("ignored");
      model_frame();
      check_stream("start_while_busy");
      check_done("start_while_busy", 2);
      clear_capture();
      pulse_stop();
      repeat (5) @(negedge clk);
      checks++;
      if (got_q.size() != 0 || busy !== 1'b0 || pix_count !== PW'(2)) begin
         errors++;
         $display("FAIL stop_in_idle: pushes=%0d busy=%b cnt=%0d, expected 0,0,2",
                  got_q.size(), busy, pix_count);
      end
      $display("stop_in_idle: pushes=%0d busy=%b", got_q.size(), busy);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset_mid();
      bit ok;
      clear_capture();
      pulse_start();
      send_pixel(24'hAABBCC, ok);
      if (!ok) report_timeout("reset_mid");
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (push !== 1'b0 || busy !== 1'b0 || rgb_ready !== 1'b0 || pix_count !== '0) begin
         errors++;
         $display("FAIL reset_mid: push=%b busy=%b ready=%b cnt=%0d, expected 0,0,0,0",
                  push, busy, rgb_ready, pix_count);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      px_q = '{24'h0A0B0C};
      run_frame("after_reset", 0);
   endtask

   task automatic test_two_pixel();
      px_q = '{24'h010203, 24'h0F0000};
      run_frame("two_pixel", 0);
   endtask

   task automatic test_random_frames();
      int np;
      rand_full_en = 1'b1;
      for (int f = 0; f < 6; f++) begin
         np = $urandom_range(0, 4);
         px_q.delete();
         for (int k = 0; k < np; k++) px_q.push_back(24'($urandom));
         run_frame($sformatf("random%0d", f), 4);
      end
      rand_full_en = 1'b0;
      @(posedge clk);
      #2 full = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_pixel();
      test_full_stall();
      test_valid_stop_same();
      test_ignored_controls();
      test_reset_mid();
      test_two_pixel();
      test_random_frames();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
